// File: rtl/coalescing_store_buffer.sv
// coalescing_store_buffer
//
// Store buffer between the memory stage and the data cache ufp port. Stores
// are queued in a circular FIFO of DEPTH entries and written to the cache one
// at a time, oldest first. A pending load is answered in one of three ways:
// forwarded from the youngest queued store to the same word if that store
// covers every requested byte, read from the cache if no queued store touches
// the word, or held until the overlapping stores have drained. A cache read
// always takes priority over the next store drain. At most one cache request
// is in flight at any time.
//
// Optional feature (compile-time macro SB_COALESCE_EN):
//   When defined, a store to the same word as the youngest entry merges into
//   that entry if the entry has not yet been sent to the cache.
//   When undefined, every accepted store allocates its own entry.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   st_valid/st_ready      store handshake; st_addr, st_wdata, st_wmask payload
//   ld_valid/ld_ready      load handshake; ld_addr, ld_rmask payload
//   ld_resp, ld_rdata      one-cycle load completion and its data
//   sb_ufp_addr/rmask/     cache request; all zero when no request is issued
//   wmask/wdata
//   ufp_resp, ufp_rdata    cache completion and read data
//   count, empty, full     occupancy of the buffer
module coalescing_store_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_wdata,
    input  logic [DATA_W/8-1:0]    st_wmask,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [ADDR_W-1:0]      ld_addr,
    input  logic [DATA_W/8-1:0]    ld_rmask,
    output logic                   ld_resp,
    output logic [DATA_W-1:0]      ld_rdata,
    output logic [ADDR_W-1:0]      sb_ufp_addr,
    output logic [DATA_W/8-1:0]    sb_ufp_rmask,
    output logic [DATA_W/8-1:0]    sb_ufp_wmask,
    output logic [DATA_W-1:0]      sb_ufp_wdata,
    input  logic                   ufp_resp,
    input  logic [DATA_W-1:0]      ufp_rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int MASK_W = DATA_W / 8;
    localparam int OFS    = $clog2(MASK_W);
    localparam int PW     = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ST_WAIT, LD_WAIT} state_t;
    state_t state, state_next;

    logic              e_valid [DEPTH];
    logic [ADDR_W-1:0] e_addr  [DEPTH];
    logic [DATA_W-1:0] e_data  [DEPTH];
    logic [MASK_W-1:0] e_mask  [DEPTH];

    logic [PW-1:0] head, tail, scan_idx, young_idx;

    logic              ld_pend;
    logic [ADDR_W-1:0] ld_pend_addr;
    logic [MASK_W-1:0] ld_pend_rmask;

    logic              any_match, ld_hit, ld_miss;
    logic              issue_ld, issue_st, pop, ld_cache_done;
    logic              merge, st_fire, alloc;
    logic [DATA_W-1:0] hit_data;

    // Only the word part of an address takes part in matching.
    function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                        input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:OFS] == b[ADDR_W-1:OFS];
    endfunction

    // Walk from oldest to youngest so the last hit seen is the youngest store.
    always_comb begin
        any_match = 1'b0;
        young_idx = head;
        scan_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (e_valid[scan_idx] && word_match(e_addr[scan_idx], ld_pend_addr)) begin
                any_match = 1'b1;
                young_idx = scan_idx;
            end
        end
    end

    // Forwarded data keeps only the requested bytes.
    always_comb begin
        hit_data = '0;
        for (int b = 0; b < MASK_W; b++) begin
            if (ld_pend_rmask[b]) begin
                hit_data[8*b +: 8] = e_data[young_idx][8*b +: 8];
            end
        end
    end

    assign ld_hit  = ld_pend && any_match && (state != LD_WAIT) &&
                     ((e_mask[young_idx] & ld_pend_rmask) == ld_pend_rmask);
    assign ld_miss = ld_pend && !any_match;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign issue_ld      = (state == IDLE) && ld_miss;
    assign issue_st      = (state == IDLE) && !ld_miss && !empty;
    assign pop           = (state == ST_WAIT) && ufp_resp;
    assign ld_cache_done = (state == LD_WAIT) && ufp_resp;

`ifdef SB_COALESCE_EN
    logic          e_issued [DEPTH];
    logic [PW-1:0] last;

    // The youngest entry may still absorb stores until it is sent out; an
    // entry being sent this very cycle already carries its old data.
    assign last  = tail - 1'b1;
    assign merge = e_valid[last] && !e_issued[last] &&
                   !(issue_st && (last == head)) &&
                   word_match(e_addr[last], st_addr);
`else
    assign merge = 1'b0;
`endif

    // A pending load freezes the store side so no younger store can slip in.
    assign st_ready = !ld_pend && (!full || merge);
    assign ld_ready = !ld_pend;
    assign st_fire  = st_valid && st_ready;
    assign alloc    = st_fire && !merge;

    assign ld_resp  = ld_hit || ld_cache_done;
    assign ld_rdata = ld_cache_done ? ufp_rdata : (ld_hit ? hit_data : '0);

    // Entry storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i] <= 1'b0;
`ifdef SB_COALESCE_EN
                e_issued[i] <= 1'b0;
`endif
            end
        end else begin
            if (alloc) begin
                e_valid[tail] <= 1'b1;
                e_addr[tail]  <= st_addr;
                e_data[tail]  <= st_wdata;
                e_mask[tail]  <= st_wmask;
                tail          <= tail + 1'b1;
`ifdef SB_COALESCE_EN
                e_issued[tail] <= 1'b0;
`endif
            end
`ifdef SB_COALESCE_EN
            if (st_fire && merge) begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (st_wmask[b]) begin
                        e_data[last][8*b +: 8] <= st_wdata[8*b +: 8];
                    end
                end
                e_mask[last] <= e_mask[last] | st_wmask;
            end
            if (issue_st) begin
                e_issued[head] <= 1'b1;
            end
`endif
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (alloc && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !alloc) begin
                count <= count - 1'b1;
            end
        end
    end

    // Pending load register; cleared on the cycle its response is given.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_pend       <= 1'b0;
            ld_pend_addr  <= '0;
            ld_pend_rmask <= '0;
        end else if (ld_valid && ld_ready) begin
            ld_pend       <= 1'b1;
            ld_pend_addr  <= ld_addr;
            ld_pend_rmask <= ld_rmask;
        end else if (ld_resp) begin
            ld_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Cache requests are presented only on the cycle the FSM leaves IDLE.
    always_comb begin
        state_next   = state;
        sb_ufp_addr  = '0;
        sb_ufp_rmask = '0;
        sb_ufp_wmask = '0;
        sb_ufp_wdata = '0;
        case (state)
            IDLE: begin
                if (issue_ld) begin
                    state_next   = LD_WAIT;
                    sb_ufp_addr  = ld_pend_addr;
                    sb_ufp_rmask = ld_pend_rmask;
                end else if (issue_st) begin
                    state_next   = ST_WAIT;
                    sb_ufp_addr  = e_addr[head];
                    sb_ufp_wmask = e_mask[head];
                    sb_ufp_wdata = e_data[head];
                end
            end
            ST_WAIT: if (ufp_resp) state_next = IDLE;
            LD_WAIT: if (ufp_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coalescing_store_buffer.sv
// tb_coalescing_store_buffer
//
// Drives coalescing_store_buffer (DEPTH=8, 32-bit address and data) while
// acting as the data cache. A queue-based reference model predicts every
// output each cycle; directed scenarios add literal expectations.
`timescale 1ns/1ps
module tb_coalescing_store_buffer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0, st_ready;
    logic [31:0] st_addr = '0, st_wdata = '0;
    logic [3:0]  st_wmask = '0;
    logic        ld_valid = 1'b0, ld_ready;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_rmask = '0;
    logic        ld_resp;
    logic [31:0] ld_rdata;
    logic [31:0] sb_ufp_addr, sb_ufp_wdata;
    logic [3:0]  sb_ufp_rmask, sb_ufp_wmask;
    logic        ufp_resp = 1'b0;
    logic [31:0] ufp_rdata = '0;
    logic [3:0]  count;
    logic        empty, full;

    always #5 clk = ~clk;

    coalescing_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_wmask(st_wmask),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_rmask(ld_rmask), .ld_resp(ld_resp), .ld_rdata(ld_rdata),
        .sb_ufp_addr(sb_ufp_addr), .sb_ufp_rmask(sb_ufp_rmask),
        .sb_ufp_wmask(sb_ufp_wmask), .sb_ufp_wdata(sb_ufp_wdata),
        .ufp_resp(ufp_resp), .ufp_rdata(ufp_rdata),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        bit          issued;
    } ent_t;

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    // Reference model: queued stores oldest-first, pending load, cache port.
    ent_t        mq[$];
    bit          m_ld_pend = 0;
    logic [31:0] m_ld_addr = '0;
    logic [3:0]  m_ld_rmask = '0;
    int          m_busy = 0;      // 0 none, 1 write outstanding, 2 read outstanding
    int          m_lat = 0;

    // Staged inputs and cache behaviour knobs.
    bit          s_rst = 1, s_st_valid = 0, s_ld_valid = 0;
    logic [31:0] s_st_addr = '0, s_st_wdata = '0, s_ld_addr = '0;
    logic [3:0]  s_st_wmask = '0, s_ld_rmask = '0;
    bit          hold_resp = 0, fixed_lat_mode = 1, use_fixed_rdata = 1, stray_resp = 0;
    int          fixed_lat = 0;
    logic [31:0] fixed_rdata = 32'hCAFEF00D;
    req_t        req_log[$];

    int compared = 0, mismatched = 0;

    // Per-cycle expectations.
    bit          e_st_ready, e_ld_ready, e_ld_resp, e_full, e_empty;
    bit          e_issue_rd, e_issue_wr, e_merge;
    logic [31:0] e_ld_rdata, e_addr, e_wdata;
    logic [3:0]  e_rmask, e_wmask;
    int          e_count;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] keepBytes(input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit sameWord(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    task automatic computeExpect();
        int  y;
        bit  hit, miss;
        y = -1;
        for (int j = 0; j < mq.size(); j++) if (sameWord(mq[j].addr, m_ld_addr)) y = j;
        miss = m_ld_pend && (y < 0);
        hit  = 0;
        if (m_ld_pend && y >= 0 && m_busy != 2)
            hit = ((mq[y].mask & m_ld_rmask) == m_ld_rmask);
        e_issue_rd = (m_busy == 0) && miss;
        e_issue_wr = (m_busy == 0) && !miss && (mq.size() > 0);
        e_ld_resp  = hit || (m_busy == 2 && ufp_resp);
        e_ld_rdata = '0;
        if (m_busy == 2 && ufp_resp) e_ld_rdata = ufp_rdata;
        else if (hit) e_ld_rdata = keepBytes(mq[y].data, m_ld_rmask);
        e_merge = 0;
`ifdef SB_COALESCE_EN
        if (mq.size() > 0)
            e_merge = !mq[mq.size()-1].issued && sameWord(mq[mq.size()-1].addr, st_addr) &&
                      !(e_issue_wr && mq.size() == 1);
`endif
        e_count    = mq.size();
        e_full     = (mq.size() == DEPTH);
        e_empty    = (mq.size() == 0);
        e_st_ready = !m_ld_pend && (!e_full || e_merge);
        e_ld_ready = !m_ld_pend;
        e_addr = '0; e_rmask = '0; e_wmask = '0; e_wdata = '0;
        if (e_issue_rd) begin
            e_addr  = m_ld_addr;
            e_rmask = m_ld_rmask;
        end else if (e_issue_wr) begin
            e_addr  = mq[0].addr;
            e_wmask = mq[0].mask;
            e_wdata = mq[0].data;
        end
    endtask

    task automatic compareModel();
        checkOutput("st_ready", st_ready, e_st_ready);
        checkOutput("ld_ready", ld_ready, e_ld_ready);
        checkOutput("ld_resp", ld_resp, e_ld_resp);
        if (e_ld_resp) checkOutput("ld_rdata", ld_rdata, e_ld_rdata);
        checkOutput("ufp_addr", sb_ufp_addr, e_addr);
        checkOutput("ufp_rmask", sb_ufp_rmask, e_rmask);
        checkOutput("ufp_wmask", sb_ufp_wmask, e_wmask);
        checkOutput("ufp_wdata", sb_ufp_wdata, e_wdata);
        checkOutput("count", count, e_count);
        checkOutput("empty", empty, e_empty);
        checkOutput("full", full, e_full);
    endtask

    task automatic modelAdvance();
        ent_t e;
        bit st_fire, ld_fire;
        st_fire = st_valid && e_st_ready;
        ld_fire = ld_valid && e_ld_ready;
        if (st_fire && e_merge) begin
            e = mq[mq.size()-1];
            for (int b = 0; b < 4; b++) if (st_wmask[b]) e.data[8*b +: 8] = st_wdata[8*b +: 8];
            e.mask = e.mask | st_wmask;
            mq[mq.size()-1] = e;
        end
        if (e_ld_resp) m_ld_pend = 0;
        if (m_busy == 1 && ufp_resp) begin
            void'(mq.pop_front());
            m_busy = 0;
        end else if (m_busy == 2 && ufp_resp) begin
            m_busy = 0;
        end
        if (e_issue_wr) begin
            e = mq[0];
            e.issued = 1;
            mq[0] = e;
            m_busy = 1;
            m_lat = fixed_lat_mode ? fixed_lat : $urandom_range(0, 3);
        end
        if (e_issue_rd) begin
            m_busy = 2;
            m_lat = fixed_lat_mode ? fixed_lat : $urandom_range(0, 3);
        end
        if (st_fire && !e_merge) begin
            e.addr = st_addr; e.data = st_wdata; e.mask = st_wmask; e.issued = 0;
            mq.push_back(e);
        end
        if (ld_fire) begin
            m_ld_pend  = 1;
            m_ld_addr  = ld_addr;
            m_ld_rmask = ld_rmask;
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_ld_pend = 0;
        m_busy = 0;
        m_lat = 0;
        stray_resp = 1;
    endtask

    // Drive one cycle's inputs, including the cache's response.
    task automatic applyStimulus();
        rst      = s_rst;
        st_valid = s_st_valid; st_addr = s_st_addr; st_wdata = s_st_wdata; st_wmask = s_st_wmask;
        ld_valid = s_ld_valid; ld_addr = s_ld_addr; ld_rmask = s_ld_rmask;
        if (s_rst) ufp_resp = 1'b0;
        else if (stray_resp) begin
            ufp_resp = 1'b1;
            stray_resp = 0;
        end else if (hold_resp || m_busy == 0) ufp_resp = 1'b0;
        else if (m_lat == 0) ufp_resp = 1'b1;
        else begin
            ufp_resp = 1'b0;
            m_lat--;
        end
        ufp_rdata = use_fixed_rdata ? fixed_rdata : $urandom();
    endtask

    task automatic runCycle();
        req_t r;
        @(negedge clk);
        applyStimulus();
        #1;
        if (rst) begin
            modelReset();
        end else begin
            computeExpect();
            compareModel();
            if (sb_ufp_wmask != 4'h0 || sb_ufp_rmask != 4'h0) begin
                r.is_read = (sb_ufp_rmask != 4'h0);
                r.addr = sb_ufp_addr; r.wmask = sb_ufp_wmask; r.wdata = sb_ufp_wdata;
                req_log.push_back(r);
            end
            modelAdvance();
        end
    endtask

    task automatic idle();
        s_st_valid = 0;
        s_ld_valid = 0;
    endtask

    task automatic setStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        s_st_valid = 1; s_st_addr = a; s_st_wdata = d; s_st_wmask = m;
    endtask

    task automatic setLoad(input logic [31:0] a, input logic [3:0] m);
        s_ld_valid = 1; s_ld_addr = a; s_ld_rmask = m;
    endtask

    task automatic waitDrain(input string name);
        int n;
        bit done;
        idle();
        n = 0;
        done = 0;
        while (!done && n < 300) begin
            runCycle();
            n++;
            done = (empty === 1'b1) && (ld_ready === 1'b1) && (m_busy == 0);
        end
        checkOutput(name, {63'b0, !done}, 64'd0);
    endtask

    function automatic logic [31:0] randAddr();
        return 32'h100 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        // Reset and reset values.
        s_rst = 1; idle();
        runCycle(); runCycle();
        s_rst = 0;
        runCycle();
        checkOutput("rst_st_ready", st_ready, 1);
        checkOutput("rst_ld_ready", ld_ready, 1);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_ld_resp", ld_resp, 0);
        checkOutput("rst_ld_rdata", ld_rdata, 0);
        checkOutput("rst_ufp", {sb_ufp_addr, sb_ufp_wdata}, 64'd0);
        checkOutput("rst_ufp_masks", {sb_ufp_rmask, sb_ufp_wmask}, 0);

        // Full-coverage forward: answered at T+1 without a cache read.
        fixed_lat_mode = 1; fixed_lat = 0; use_fixed_rdata = 1;
        setStore(32'h100, 32'hDEADBEEF, 4'hF); runCycle(); idle();
        setLoad(32'h100, 4'h3); runCycle(); idle();
        runCycle();
        checkOutput("fwd_resp", ld_resp, 1);
        checkOutput("fwd_data", ld_rdata, 32'h0000BEEF);
        checkOutput("fwd_no_read", sb_ufp_rmask, 0);
        waitDrain("fwd_drain");

        // Partial coverage: wait for the store, then read from the cache.
        setStore(32'h100, 32'h12345678, 4'h3); runCycle(); idle();
        setLoad(32'h100, 4'hF); runCycle(); idle();
        runCycle();
        checkOutput("conf_no_resp", ld_resp, 0);
        runCycle();
        checkOutput("conf_rd_mask", sb_ufp_rmask, 4'hF);
        checkOutput("conf_rd_addr", sb_ufp_addr, 32'h100);
        checkOutput("conf_no_resp2", ld_resp, 0);
        runCycle();
        checkOutput("conf_resp", ld_resp, 1);
        checkOutput("conf_data", ld_rdata, 32'hCAFEF00D);
        waitDrain("conf_drain");

        // Fill to full with wrapped pointers, then drain in FIFO order.
        req_log.delete();
        hold_resp = 1;
        for (int i = 0; i < DEPTH; i++) begin
            setStore(32'h1000 + 32'(i) * 16, 32'hA0 + 32'(i) * 32'h01010101, 4'hF);
            runCycle();
        end
        idle(); runCycle();
        checkOutput("fill_full", full, 1);
        checkOutput("fill_st_ready", st_ready, 0);
        checkOutput("fill_count", count, DEPTH);
        hold_resp = 0;
        waitDrain("fill_drain");
        checkOutput("fill_log_size", req_log.size(), DEPTH);
        for (int i = 0; i < req_log.size() && i < DEPTH; i++)
            checkOutput("fill_order", req_log[i].addr, 32'h1000 + 32'(i) * 16);
        checkOutput("fill_final_count", count, 0);

        // A miss overtakes queued stores.
        req_log.delete();
        hold_resp = 1;
        setStore(32'h300, 32'h1, 4'hF); runCycle();
        setStore(32'h310, 32'h2, 4'hF); runCycle();
        setStore(32'h320, 32'h3, 4'hF); runCycle(); idle();
        setLoad(32'h200, 4'hF); runCycle(); idle(); runCycle();
        hold_resp = 0;
        waitDrain("miss_drain");
        checkOutput("miss_log_size", req_log.size(), 4);
        if (req_log.size() >= 3) begin
            checkOutput("miss_first_wr", {req_log[0].is_read, req_log[0].addr}, {1'b0, 32'h300});
            checkOutput("miss_read", {req_log[1].is_read, req_log[1].addr}, {1'b1, 32'h200});
            checkOutput("miss_next_wr", {req_log[2].is_read, req_log[2].addr}, {1'b0, 32'h310});
        end

`ifdef SB_COALESCE_EN
        // Two stores to one word merge while an older write is outstanding.
        req_log.delete();
        hold_resp = 1;
        setStore(32'h400, 32'h5, 4'hF); runCycle();
        setStore(32'h104, 32'h00000011, 4'h1); runCycle();
        setStore(32'h104, 32'h00220000, 4'h4); runCycle(); idle();
        runCycle();
        checkOutput("coal_count", count, 2);
        hold_resp = 0;
        waitDrain("coal_drain");
        checkOutput("coal_log_size", req_log.size(), 2);
        if (req_log.size() >= 2) begin
            checkOutput("coal_wmask", req_log[1].wmask, 4'h5);
            checkOutput("coal_wdata", req_log[1].wdata, 32'h00220011);
        end
`endif

        // Randomized traffic with random cache latency and occasional reset.
        fixed_lat_mode = 0; use_fixed_rdata = 0;
        for (int c = 0; c < 4000; c++) begin
            s_rst      = ($urandom_range(0, 499) == 0);
            s_st_valid = $urandom_range(0, 1);
            s_st_addr  = randAddr();
            s_st_wdata = $urandom();
            s_st_wmask = 4'($urandom_range(1, 15));
            s_ld_valid = ($urandom_range(0, 3) == 0);
            s_ld_addr  = randAddr();
            s_ld_rmask = 4'($urandom_range(1, 15));
            hold_resp  = ($urandom_range(0, 7) == 0);
            runCycle();
        end
        s_rst = 0;
        hold_resp = 0;
        waitDrain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/coalescing_store_buffer.md
# coalescing_store_buffer

Parametrised store buffer between the memory stage and the data cache `ufp_*` port. It queues up to DEPTH stores in a circular FIFO and drains them to the cache one at a time. Pending loads are served by store-to-load forwarding, by bypassing queued stores, or by stalling until conflicting stores drain. It generalises the fixed 4-entry, exact-match buffer with configurable depth and width, a ready/valid handshake, byte-mask coverage forwarding, load-over-store priority and optional write coalescing.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, data width; MASK_W = DATA_W/8; word offset bits OFS = log2(MASK_W)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- st_valid  in  1  store request
- st_ready  out  1  store accepted when st_valid && st_ready
- st_addr  in  ADDR_W  store address
- st_wdata  in  DATA_W  store data
- st_wmask  in  MASK_W  store byte mask; must be nonzero when st_valid
- ld_valid  in  1  load request
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- ld_addr  in  ADDR_W  load address
- ld_rmask  in  MASK_W  load byte mask; must be nonzero when ld_valid
- ld_resp  out  1  one-cycle load completion pulse
- ld_rdata  out  DATA_W  load data; valid only while ld_resp
- sb_ufp_addr  out  ADDR_W  cache address
- sb_ufp_rmask  out  MASK_W  cache read mask
- sb_ufp_wmask  out  MASK_W  cache write mask
- sb_ufp_wdata  out  DATA_W  cache write data
- ufp_resp  in  1  cache completion
- ufp_rdata  in  DATA_W  cache read data
- count  out  log2(DEPTH)+1  occupied entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Entry fields: valid, addr, data, mask, issued. Pointers are head (oldest) and tail (next free), each log2(DEPTH) bits and wrapping modulo DEPTH.
- Address match compares addr[ADDR_W-1:OFS] only.
- Store acceptance writes the entry at tail, advances tail and increments count. st_ready = !full && !ld_pend. While a load is pending, no younger store can enter.
- Load acceptance captures addr and rmask into ld_pend. ld_ready = !ld_pend.
- Pending-load resolution is evaluated every cycle against all valid entries:
  - Hit: the youngest matching entry satisfies (mask & rmask) == rmask. Respond from that entry. Bytes outside rmask are driven as 0.
  - Conflict: a match exists but does not cover rmask. Wait for the matching entries to drain.
  - Miss: no match. Read from the cache.
- Drain FSM states and transitions:
  - IDLE → LD_WAIT when a miss is pending. Drive rmask and addr for exactly that cycle. Loads have priority over store drain.
  - IDLE → ST_WAIT when !empty and no miss is pending. Drive the head entry's wmask, wdata and addr for one cycle, and set its issued bit.
  - ST_WAIT → IDLE on ufp_resp: pop head, decrement count.
  - LD_WAIT → IDLE on ufp_resp: ld_resp=1 and ld_rdata=ufp_rdata in the same cycle; clear ld_pend.
- Simultaneous store accept and head pop in the same cycle: count is unchanged and both pointers advance.
- All sb_ufp_* outputs are 0 on every cycle in which no request is issued. At most one cache request is outstanding.

## Timing
- Reset values: st_ready=1, ld_ready=1, empty=1, full=0, count=0; ld_resp, ld_rdata and all sb_ufp_* = 0. FSM state is IDLE and all entries are invalid.
- Reset mid-operation discards all entries and the pending load. A ufp_resp arriving after reset is ignored in IDLE.
- Forward latency: load accepted at cycle T gives ld_resp at T+1 at the earliest. Resolution uses registered entry state, so a store accepted at T is visible to it.
- Cache load: request issued at T+1 at the earliest, when the FSM is IDLE. ld_resp arrives on the same cycle as ufp_resp.
- Store drain: the head request is issued the cycle after the FSM reaches IDLE, or at T+1 after acceptance into an empty buffer. The pop occurs on the ufp_resp cycle.
- full is computed from registered count, so a same-cycle pop does not raise st_ready.

## Configuration
- SB_COALESCE_EN defined:
  - An accepted store merges into the youngest entry (tail-1) if that entry is valid, has not been issued and matches the store's address.
  - Merge rule: data bytes under st_wmask are overwritten, and mask |= st_wmask. No allocation occurs and count is unchanged.
  - st_ready is also 1 when full, provided the merge condition holds.
- SB_COALESCE_EN undefined: every accepted store allocates a new entry.

## Test plan
- Reset → st_ready=1, ld_ready=1, empty=1, count=0, and every sb_ufp_* = 0.
- Store 0x100/0xDEADBEEF/1111, then load 0x100 rmask 0011 → ld_resp at T+1 with ld_rdata=0x0000BEEF, and no cache read is issued.
- Store 0x100 mask 0011, then load 0x100 rmask 1111 → no ld_resp until that store's ufp_resp; then one cache read to 0x100, and ld_resp returns ufp_rdata.
- Fill DEPTH=8 stores to distinct addresses → full=1, st_ready=0. The cache drains them in FIFO order with pointer wrap, then count=0.
- With 3 stores queued, load 0x200 (miss) → the cache read to 0x200 is issued before the next store drain.
- With SB_COALESCE_EN, store 0x104 mask 0001 data 0x11, then 0x104 mask 0100 data 0x00220000, both before issue → count=1; a single write with wmask=0101 and wdata=0x00220011.
